// File: rtl/adc_sequencer.sv
// SAR ADC host sequencer: issues start pulses, edge-detects conversion-complete,
// averages 2^k results and queues the averages in a show-ahead valid/ready FIFO.
module adc_sequencer #(
  parameter int RESOLUTION   = 8,
  parameter int AVG_MAX_LOG2 = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic                              trig_i,
  input  logic [$clog2(AVG_MAX_LOG2+1)-1:0] avg_log2_i,
  input  logic                              clr_i,
  output logic                              start_o,
  input  logic                              adc_rdy_i,
  input  logic [RESOLUTION-1:0]             adc_result_i,
  output logic [RESOLUTION-1:0]             data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              busy_o,
  output logic                              overflow_o
);
  localparam int KW = $clog2(AVG_MAX_LOG2+1);
  localparam int AW = RESOLUTION + AVG_MAX_LOG2;
  localparam int CW = AVG_MAX_LOG2 + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CONT, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [KW-1:0]         r_k, w_k_clamp;
  logic [AW-1:0]         r_acc, w_acc_sum;
  logic [CW-1:0]         r_cnt, w_cnt_inc;
  logic                  r_rdy_prev, r_start_prev;
  logic                  w_evt, w_capture, w_block_done, w_push;
  logic [RESOLUTION-1:0] w_avg;

  logic [RESOLUTION-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0]           r_wptr, r_rptr;
  logic                  w_empty, w_full, w_pop, w_wr, w_ovf_set;
  logic                  r_ovf;

  assign w_k_clamp    = (avg_log2_i > KW'(AVG_MAX_LOG2)) ? KW'(AVG_MAX_LOG2) : avg_log2_i;
  assign w_evt        = adc_rdy_i && !r_rdy_prev;
  assign w_capture    = w_evt && (r_state inside {S_WAIT, S_CONT, S_DRAIN});
  assign w_acc_sum    = r_acc + AW'(adc_result_i);
  assign w_cnt_inc    = r_cnt + CW'(1);
  assign w_block_done = (w_cnt_inc == (CW'(1) << r_k));
  assign w_avg        = RESOLUTION'(w_acc_sum >> r_k);
  assign w_push       = w_capture && w_block_done;

  assign start_o = (r_state == S_ISSUE) || (r_state == S_CONT);
  assign busy_o  = (r_state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // DRAIN exits only on the conversion the ADC ran without a restart request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en_i)        w_state_nxt = S_CONT;
        else if (trig_i) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_evt) w_state_nxt = w_block_done ? S_IDLE : S_ISSUE;
      S_CONT:  if (!en_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_evt && !r_start_prev) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_rdy_prev   <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_rdy_prev   <= adc_rdy_i;
      r_start_prev <= start_o;
      if (r_state == S_IDLE) begin
        r_k   <= w_k_clamp;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_capture) begin
        if (w_block_done) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  // A pop frees the slot this edge, so a push into a full FIFO still lands.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop     = !w_empty && ready_i;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[PW-1:0]] <= w_avg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (PW+1)'(1);
      if (w_ovf_set)  r_ovf <= 1'b1;
      else if (clr_i) r_ovf <= 1'b0;
    end
  end

  assign valid_o    = !w_empty;
  assign data_o     = w_empty ? '0 : r_mem[r_rptr[PW-1:0]];
  assign overflow_o = r_ovf;

endmodule
